// File: rtl/md_issue_ctrl_if.sv
// Handshake bundle for md_issue_ctrl. It covers the execute-stage request,
// the multdiv start/result signals and the writeback beat.
interface md_issue_ctrl_if;
   logic        start_mult;
   logic        start_div;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [4:0]  dest_reg;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ready;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] md_operand_a;
   logic [31:0] md_operand_b;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   logic        wb_exception;

   // Environment side: the execute stage and the multdiv unit.
   modport master (
      output start_mult, start_div, operand_a, operand_b, dest_reg,
      output md_result, md_exception, md_ready,
      input  ctrl_MULT, ctrl_DIV, md_operand_a, md_operand_b,
      input  stall, wb_valid, wb_reg, wb_data, wb_exception
   );

   // Controller side.
   modport slave (
      input  start_mult, start_div, operand_a, operand_b, dest_reg,
      input  md_result, md_exception, md_ready,
      output ctrl_MULT, ctrl_DIV, md_operand_a, md_operand_b,
      output stall, wb_valid, wb_reg, wb_data, wb_exception
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multdiv unit. It stalls execute, pulses ctrl_MULT/ctrl_DIV,
// waits for a non-stale ready or a timeout, then emits one writeback beat.
module md_issue_ctrl #(
   parameter int TIMEOUT       = 40,
   parameter int RSTATUS_REG   = 30,
   parameter int MULT_EXC_CODE = 4,
   parameter int DIV_EXC_CODE  = 5
) (
   input logic            clock,
   input logic            reset,
   md_issue_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [5:0] TIMEOUT_CNT = (TIMEOUT > 63) ? 6'd63 : 6'(TIMEOUT);

   state_t      state_q, state_d;
   logic        is_mult_q, is_mult_d;
   logic [31:0] op_a_q, op_a_d;
   logic [31:0] op_b_q, op_b_d;
   logic [4:0]  dest_q, dest_d;
   logic [31:0] result_q, result_d;
   logic        exc_q, exc_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        guard_q, guard_d;
   logic        ctrl_mult_q, ctrl_mult_d;
   logic        ctrl_div_q, ctrl_div_d;

   logic        start_any;
   logic [5:0]  cnt_inc;

   assign start_any = bus.start_mult | bus.start_div;
   assign cnt_inc   = (cnt_q == 6'h3F) ? cnt_q : cnt_q + 6'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         is_mult_q   <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         dest_q      <= '0;
         result_q    <= '0;
         exc_q       <= 1'b0;
         cnt_q       <= '0;
         guard_q     <= 1'b0;
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_mult_q   <= is_mult_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         dest_q      <= dest_d;
         result_q    <= result_d;
         exc_q       <= exc_d;
         cnt_q       <= cnt_d;
         guard_q     <= guard_d;
         ctrl_mult_q <= ctrl_mult_d;
         ctrl_div_q  <= ctrl_div_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      is_mult_d   = is_mult_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      dest_d      = dest_q;
      result_d    = result_q;
      exc_d       = exc_q;
      cnt_d       = cnt_q;
      guard_d     = guard_q;
      ctrl_mult_d = 1'b0;
      ctrl_div_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_any) begin
               // MULT has priority when both starts are raised together.
               is_mult_d   = bus.start_mult;
               op_a_d      = bus.operand_a;
               op_b_d      = bus.operand_b;
               dest_d      = bus.dest_reg;
               ctrl_mult_d = bus.start_mult;
               ctrl_div_d  = ~bus.start_mult;
               state_d     = ST_PULSE;
            end
         end
         ST_PULSE: begin
            cnt_d   = '0;
            guard_d = 1'b0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            guard_d = 1'b1;
            cnt_d   = cnt_inc;
            // The first WAIT cycle may still see ready from the previous operation.
            if (guard_q && bus.md_ready) begin
               result_d = bus.md_result;
               exc_d    = bus.md_exception;
               state_d  = ST_DONE;
            end else if (cnt_inc >= TIMEOUT_CNT) begin
               result_d = '0;
               exc_d    = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   logic done;
   assign done = (state_q == ST_DONE);

   assign bus.ctrl_MULT    = ctrl_mult_q;
   assign bus.ctrl_DIV     = ctrl_div_q;
   assign bus.md_operand_a = op_a_q;
   assign bus.md_operand_b = op_b_q;
   // Combinational so the instruction is held on its very first cycle in execute.
   assign bus.stall        = ~reset & ((state_q == ST_PULSE) || (state_q == ST_WAIT) ||
                                       ((state_q == ST_IDLE) && start_any));
   assign bus.wb_valid     = done;
   assign bus.wb_exception = done & exc_q;
   assign bus.wb_reg       = !done ? 5'd0 : (exc_q ? 5'(RSTATUS_REG) : dest_q);
   assign bus.wb_data      = !done ? 32'd0 :
                             (exc_q ? (is_mult_q ? 32'(MULT_EXC_CODE) : 32'(DIV_EXC_CODE))
                                    : result_q);

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Sequencing controller between the execute stage and the `multdiv` unit. It accepts a MULT or DIV request from execute and holds the pipeline stalled while the unit computes. It issues the one-cycle `ctrl_MULT`/`ctrl_DIV` pulse with stable operands, then waits for `data_resultRDY`, guarding against a stale ready from the previous operation. It presents a single-cycle writeback beat: the result to `rd`, or the exception code to `$rstatus` when the unit reports an exception or times out.

## Interface
Parameters:
- `TIMEOUT`, 40 — maximum WAIT cycles before the operation is forced to complete with an exception.
- `RSTATUS_REG`, 30 — destination register used for exception writeback.
- `MULT_EXC_CODE`, 4 — `wb_data` value written on a MULT exception.
- `DIV_EXC_CODE`, 5 — `wb_data` value written on a DIV exception.

Ports:
- `clock`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-high; forces IDLE and clears all registers.
- `start_mult`  in  1  — execute stage holds a MULT instruction.
- `start_div`  in  1  — execute stage holds a DIV instruction.
- `operand_a`, `operand_b`  in  32 each — execute-stage source operands.
- `dest_reg`  in  5  — execute-stage `rd`.
- `md_result`  in  32 — from `multdiv` `data_result`.
- `md_exception`  in  1  — from `multdiv` `data_exception`.
- `md_ready`  in  1  — from `multdiv` `data_resultRDY`.
- `ctrl_MULT`, `ctrl_DIV`  out  1 each — registered start pulses to `multdiv`.
- `md_operand_a`, `md_operand_b`  out  32 each — latched operands to `multdiv`.
- `stall`  out  1  — freezes PC and the F/D and D/X latches.
- `wb_valid`  out  1  — writeback beat is valid.
- `wb_reg`  out  5  — writeback destination register.
- `wb_data`  out  32 — writeback value.
- `wb_exception`  out  1  — current writeback is an exception write.

## Operation
- States: IDLE, PULSE, WAIT, DONE. 2-bit encoding.
- IDLE:
  - If `start_mult` or `start_div` is high, capture `operand_a`, `operand_b`, `dest_reg` and the op type (`start_mult` wins if both are high), then go to PULSE.
- PULSE:
  - Exactly one of `ctrl_MULT`/`ctrl_DIV` is 1, per the captured op type.
  - Clear the wait counter and the guard flag.
  - Next state is WAIT.
- WAIT:
  - `md_ready` is ignored in the first WAIT cycle (guard).
  - In any later cycle, `md_ready`=1 captures `md_result` and `md_exception` and goes to DONE.
  - If the counter reaches `TIMEOUT` without ready, go to DONE with the exception forced.
  - The counter is 6 bits, saturating.
- DONE:
  - `wb_valid`=1 for one cycle; next state is IDLE.
  - Start inputs are ignored in DONE, because they still reflect the instruction being retired.
- Writeback, no exception: `wb_reg` = captured `dest_reg`, `wb_data` = captured result, `wb_exception`=0.
- Writeback, exception or timeout:
  - `wb_reg` = `RSTATUS_REG`, `wb_exception`=1.
  - `wb_data` = `MULT_EXC_CODE` or `DIV_EXC_CODE`, zero-extended to 32 bits.
- Outputs:
  - `stall` = (state is PULSE or WAIT) or (state is IDLE and either start is high). This is combinational, so the instruction cannot advance on its first cycle in execute.
  - `md_operand_a`/`md_operand_b` are driven from the capture registers at all times and do not change outside IDLE-accept.
- Reset mid-operation:
  - All state and outputs go to 0 and the state returns to IDLE.
  - `multdiv` is not reset; it is reinitialised by the next ctrl pulse.
  - An in-flight result is discarded and no writeback is issued.

## Timing
- Reset values: `ctrl_MULT`=0, `ctrl_DIV`=0, `stall`=0, `wb_valid`=0, `wb_reg`=0, `wb_data`=0, `wb_exception`=0, `md_operand_a`=0, `md_operand_b`=0.
- Cycle 0: IDLE with start high; `stall`=1 combinationally.
- Cycle 1: PULSE; the ctrl pulse is high and `md_operand_*` is valid.
- Cycle 2: WAIT guard cycle.
- Cycle n≥3: `md_ready` is sampled. Ready first seen in cycle n gives DONE in cycle n+1 with `stall`=0 and `wb_valid`=1.
- Minimum latency start→`wb_valid` is 4 cycles.
- Timeout: DONE occurs no later than cycle 2+`TIMEOUT`.
- Back-to-back operations: after DONE, the following IDLE cycle accepts the next start. Issue spacing is therefore a minimum of 5 cycles.
- `ctrl_MULT` and `ctrl_DIV` are never high together and never high for more than one consecutive cycle.

## Test plan
- MULT 7 × -6, unit ready after 17 cycles → one `ctrl_MULT` pulse; `wb_valid` with `wb_reg`=`dest_reg`, `wb_data`=0xFFFFFFD6, `wb_exception`=0; `stall` high from cycle 0 through the last WAIT cycle.
- DIV 100 / 0, unit reports exception → `wb_reg`=30, `wb_data`=5, `wb_exception`=1.
- MULT 0x40000000 × 4 (overflow) → `wb_reg`=30, `wb_data`=4, `wb_exception`=1.
- Stale `md_ready`=1 held high during PULSE and the guard cycle, real ready in cycle 5 → DONE in cycle 6, not earlier.
- `md_ready` never asserted → DONE at cycle 42 with `wb_reg`=30 and the exception code for the op type.
- `reset` pulsed in WAIT → all outputs 0 immediately; a new DIV accepted after reset completes normally; `start_mult` and `start_div` asserted together → a `ctrl_MULT` pulse only.
